// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the IF/D main-memory arbiter.
// Used by mem_arbiter (optional MEM_ARB_ROUND_ROBIN_EN) and mem_arb_lane.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        RMW_RD,
        RMW_WR,
        ERR,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    // Size 2'b11 is never legal, so it is reported as misaligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_arb_lane.sv
// Byte-lane steering: merges sub-word store data into a memory word and
// extracts/extends sub-word load data from a memory word.
module mem_arb_lane
    import mem_arb_pkg::*;
(
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        merged = rword;
        case (size)
            SZ_BYTE: begin
                case (byte_off)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (byte_off[1]) merged[31:16] = wdata[15:0];
                else             merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

    always_comb begin
        case (byte_off)
            2'd0:    byte_v = rword[7:0];
            2'd1:    byte_v = rword[15:8];
            2'd2:    byte_v = rword[23:16];
            default: byte_v = rword[31:24];
        endcase
        half_v = byte_off[1] ? rword[31:16] : rword[15:0];

        load_data = rword;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
            SZ_HALF: load_data = {{16{~is_unsigned & half_v[15]}}, half_v};
            default: load_data = rword;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF fetches and D loads/stores onto single-ported main memory.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants; default is D over IF.
//
// state  | meaning
// IDLE   | waiting; grants at most one request
// ACC    | single memory read or word write
// RMW_RD | sub-word store: read word, merge store bytes
// RMW_WR | sub-word store: write merged word
// ERR    | rejected request, memory idle
// RESP   | rvalid pulse on the owning port
module mem_arbiter #(
    parameter logic [31:0] STARTING_ADDR   = 32'h01000000,
    parameter logic [31:0] MEM_DEPTH_BYTES = 32'h00100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_read_write
);
    import mem_arb_pkg::*;

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t      last_q, last_d;
`endif

    logic        d_win, if_win;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_we, req_uns, req_bad;
    logic [31:0] lane_merged, lane_load;

    always_comb begin
        d_win  = 1'b0;
        if_win = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (d_req && if_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (last_q == OWN_D) if_win = 1'b1;
                else                 d_win  = 1'b1;
`else
                d_win = 1'b1;
`endif
            end else if (d_req) begin
                d_win = 1'b1;
            end else if (if_req) begin
                if_win = 1'b1;
            end
        end
    end

    assign d_gnt  = d_win;
    assign if_gnt = if_win;

    // Fetches are treated as word reads so both requesters share one check path.
    always_comb begin
        req_addr  = d_win ? d_addr : if_addr;
        req_size  = d_win ? d_size : SZ_WORD;
        req_we    = d_win & d_we;
        req_uns   = d_win & d_unsigned;
        req_wdata = d_win ? d_wdata : '0;
        req_bad   = misaligned(req_size, req_addr[1:0])
                  || (req_addr < STARTING_ADDR)
                  || ((req_addr - STARTING_ADDR) >= MEM_DEPTH_BYTES);
    end

    mem_arb_lane u_lane (
        .byte_off    (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rword       (mem_data_out),
        .merged      (lane_merged),
        .load_data   (lane_load)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_win || if_win) begin
                    owner_d = d_win ? OWN_D : OWN_IF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d  = d_win ? OWN_D : OWN_IF;
`endif
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_uns;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_bad;
                    rdata_d = '0;
                    if (req_bad)                          state_d = ERR;
                    else if (req_we && req_size != SZ_WORD) state_d = RMW_RD;
                    else                                  state_d = ACC;
                end
            end
            ACC: begin
                if (owner_q == OWN_IF) rdata_d = mem_data_out;
                else if (we_q)         rdata_d = '0;
                else                   rdata_d = lane_load;
                state_d = RESP;
            end
            RMW_RD: begin
                merge_d = lane_merged;
                state_d = RMW_WR;
            end
            RMW_WR:  state_d = RESP;
            ERR:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_address    = STARTING_ADDR;
        mem_data_in    = '0;
        mem_read_write = READ;
        case (state_q)
            ACC: begin
                mem_address = {addr_q[31:2], 2'b00};
                if (we_q && size_q == SZ_WORD) begin
                    mem_read_write = WRITE;
                    mem_data_in    = wdata_q;
                end
            end
            RMW_RD: mem_address = {addr_q[31:2], 2'b00};
            RMW_WR: begin
                mem_address    = {addr_q[31:2], 2'b00};
                mem_read_write = WRITE;
                mem_data_in    = merge_q;
            end
            default: ;
        endcase
        // A resetting edge must never commit a write, even mid-RMW.
        if (reset) mem_read_write = READ;
    end

    always_comb begin
        if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
        d_rvalid  = (state_q == RESP) && (owner_q == OWN_D);
        if_err    = if_rvalid & err_q;
        d_err     = d_rvalid & err_q;
        if_rdata  = if_rvalid ? rdata_q : '0;
        d_rdata   = d_rvalid ? rdata_q : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            size_q  <= SZ_WORD;
            uns_q   <= 1'b0;
            addr_q  <= STARTING_ADDR;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= OWN_IF;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported main memory between the instruction-fetch (IF) requester and the load/store data (D) requester of the RV32 core.
- Serialises accesses, word-aligns addresses, extracts and extends sub-word loads, and performs read-modify-write for byte/half stores, because main memory only writes whole words.
- Sits between the core's fetch/LSU stages and mainmem; main memory reads combinationally and writes on posedge when read_write=1.

Parameters:
- STARTING_ADDR, 32'h01000000, base byte address of main memory.
- MEM_DEPTH_BYTES, 32'h00100000, memory size; accesses outside [STARTING_ADDR, STARTING_ADDR+MEM_DEPTH_BYTES) are errors.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request (word read).
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  request accepted this cycle (combinational).
- if_rvalid  out  1  one-cycle pulse, if_rdata valid.
- if_rdata  out  32  fetched word.
- if_err  out  1  qualifies if_rvalid: misaligned or out-of-range.
- d_req  in  1  data request.
- d_we  in  1  1=store, 0=load.
- d_size  in  2  00 byte, 01 half, 10 word (11 = error).
- d_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, LSBs used for sub-word.
- d_gnt  out  1  request accepted this cycle.
- d_rvalid  out  1  one-cycle completion pulse (loads and stores).
- d_rdata  out  32  extended load data, 0 for stores.
- d_err  out  1  qualifies d_rvalid: misaligned, bad size or out-of-range.
- mem_address  out  32  to mainmem address, always word-aligned.
- mem_data_in  out  32  to mainmem data_in.
- mem_data_out  in  32  from mainmem data_out.
- mem_read_write  out  1  0=READ, 1=WRITE.

Behaviour:
- Reset: state IDLE; gnt, rvalid and err outputs 0; rdata 0; mem_read_write=0; mem_address=STARTING_ADDR; mem_data_in=0.
- States:
  - IDLE: accepts one request.
  - ACC: single memory cycle.
  - RMW_RD, RMW_WR: sub-word store.
  - ERR: no memory access.
  - RESP: drives rvalid.
- Grant in IDLE only; if_gnt/d_gnt asserted combinationally when the matching req is high and that requester wins.
  - Default fixed priority: D over IF.
  - On grant, the request fields are latched into the state registers.
- Checks at grant:
  - misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 11;
  - out of range.
  - Either check failing sends the FSM to ERR, otherwise to ACC (load, fetch, word store) or RMW_RD (byte/half store).
- ACC: mem_address={addr[31:2],2'b00}; mem_read_write=d_we&&word store; mem_data_in=wdata. mem_data_out is captured at the edge.
- RMW_RD: read word, merge wdata bytes at addr[1:0] lanes into the merge register. RMW_WR: write merged word.
- ERR: memory idle; go to RESP with err=1.
- RESP: rvalid=1 for one cycle on the owning port, err as latched; next state is IDLE.
  - A new request can be granted in the cycle after RESP, not during RESP.
- Latency, counted from the grant in cycle N:
  - fetch/load/word store/error: rvalid at N+2;
  - sub-word store: rvalid at N+3.
- Load extraction: byte lane = addr[1:0], half lane = addr[1]; extend per d_unsigned.
- mem_read_write is forced to 0 whenever reset=1, so no write occurs on a resetting edge.
  - Reset mid-operation abandons the transaction with no rvalid; a partially completed RMW leaves memory unchanged.
- Requesters hold req and fields stable until gnt. A req dropped before gnt is legal and has no effect.
- Simultaneous req while busy: gnt stays 0 and requesters wait.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN defined: a 1-bit last-winner register, reset to IF.
  - When both requesters are pending, the one that did not win the last grant wins.
  - A single requester always wins.
- Undefined: fixed D-over-IF priority; IF can be starved by back-to-back D requests.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ACC, RMW_RD, RMW_WR, ERR, RESP);
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - READ=0/WRITE=1;
  - owner enum OWN_IF/OWN_D.
- One sub-module, mem_arb_lane: combinational byte/half merge for stores and extract/extend for loads, driven by addr[1:0], size and unsigned.
- Grant logic and the FSM live in the top module.

Test Plan:
- IF read at 0x01000000 with memory word 0x00500093 -> if_gnt in cycle N, if_rvalid at N+2, if_rdata=0x00500093, if_err=0.
- D byte store 0xAB at 0x01000105 over word 0x11223344 -> d_rvalid at N+3, memory word 0x1122AB44, one write cycle only.
- D loads from 0x01000106 over word 0x80FF0000: half signed returns 0xFFFF80FF; half unsigned returns 0x000080FF; byte signed at 0x01000107 returns 0xFFFFFF80.
- if_req and d_req high together, repeated 4 times:
  - default build: D granted all 4, IF granted after;
  - with MEM_ARB_ROUND_ROBIN_EN: grants alternate D,IF,D,IF.
- Word store at 0x01000002 and fetch at 0x02000000 -> err=1 with rvalid at N+2, mem_read_write never 1, memory unchanged.
- Reset asserted in the RMW_WR cycle -> no write to memory, no d_rvalid, all outputs return to reset values next cycle.
